hls_ocr_mac_pipe: RTL
=====================

HLS_OCR_MAC_PIPE -- requirements
Module: hls_ocr_mac_pipe

Interface
REQ-001 SHALL have parameter A_W, default 11, signed width of din0.
REQ-002 SHALL have parameter B_W, default 10, signed width of din1.
REQ-003 SHALL have parameter ACC_W, default 32, signed accumulator/result width; legal range A_W+B_W-1 <= ACC_W <= 48.
REQ-004 SHALL have parameter MUL_STAGE, default 2, product register stages; legal range 1..4.
REQ-005 SHALL have parameter SAT, default 1; 1 = saturating accumulate, 0 = two's-complement wrap.
REQ-006 SHALL have port ap_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port ap_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ce, input, 1, global clock enable.
REQ-009 SHALL have port in_valid, input, 1, din0/din1/in_first/in_last are valid this cycle.
REQ-010 SHALL have port din0, input, A_W, signed multiplicand.
REQ-011 SHALL have port din1, input, B_W, signed multiplier.
REQ-012 SHALL have port in_first, input, 1, beat opens a new accumulation window.
REQ-013 SHALL have port in_last, input, 1, beat closes the window and requests a result.
REQ-014 SHALL have port dout, output, ACC_W, signed window result.
REQ-015 SHALL have port out_valid, output, 1, dout/ovf are valid.
REQ-016 SHALL have port ovf, output, 1, window overflowed (saturated or wrapped).

Function
REQ-017 A beat SHALL be accepted only when in_valid=1 and ce=1; in_valid SHALL be ignored when ce=0.
REQ-018 Product SHALL be the full-precision signed din0*din1, A_W+B_W bits, sign-extended to ACC_W+1 bits for accumulation.
REQ-019 Product SHALL pass through exactly MUL_STAGE registers, with valid/first/last flags delayed identically.
REQ-020 Accumulate stage: flagged first SHALL load acc = product; otherwise acc = acc + product.
REQ-021 With SAT=1, a sum above 2^(ACC_W-1)-1 SHALL clamp to it, and below -2^(ACC_W-1) SHALL clamp to it; with SAT=0 it SHALL wrap modulo 2^ACC_W.
REQ-022 A sticky overflow flag SHALL set on any clamp or wrap in the window and SHALL clear when a first beat is accumulated.
REQ-023 On a last beat, dout SHALL take the updated acc, ovf the updated flag, and out_valid SHALL be 1, registered at the accumulate stage: latency MUL_STAGE+1 ce-enabled cycles from acceptance.
REQ-024 out_valid SHALL be 0 on ce-enabled cycles with no last beat at the accumulate stage; dout SHALL hold its last result.
REQ-025 After a last beat, acc and the overflow flag SHALL clear to 0, so a next beat without in_first starts from 0.
REQ-026 in_first and in_last on the same beat SHALL give dout = that product, saturated per SAT.
REQ-027 Beats before any in_first after reset SHALL accumulate onto 0.
REQ-028 When ce=0, all registers, including out_valid, dout and ovf, SHALL hold; the consumer qualifies out_valid with ce.
REQ-029 Back-to-back windows (last then first on consecutive accepted beats) SHALL produce two results on consecutive ce-enabled cycles with no bubble.

Reset
REQ-030 While ap_rst_n=0, pipeline valid flags, acc, overflow flag, dout, out_valid and ovf SHALL be 0 immediately, regardless of ap_clk.
REQ-031 Reset mid-window SHALL discard all in-flight beats with no out_valid for them; the first accepted beat after release behaves per REQ-027.

Verification (A_W=11, B_W=10, ACC_W=24, MUL_STAGE=2, SAT=1 unless stated)
REQ-032 Single first+last beat, -1024 * -512 at cycle 0 -> out_valid=1 with dout=524288 and ovf=0 at cycle 3.
REQ-033 Window 3*4, -5*6, 7*-8, 100*100 on consecutive beats -> one out_valid, dout=9926, ovf=0, 3 cycles after the last beat.
REQ-034 ACC_W=20, two-beat window 1023*511 twice -> SAT=1: dout=524287, ovf=1; SAT=0: dout=-3070, ovf=1.
REQ-035 Same window as REQ-033 with ce=0 for 5 cycles mid-window -> dout=9926, latency extended by exactly 5 cycles, outputs frozen during the stall.
REQ-036 ap_rst_n pulsed low after beat 2 of a 4-beat window -> no out_valid for it; a following single-beat window 2*3 yields dout=6.
REQ-037 Windows {1*1 last} then {2*2 first+last} on consecutive beats -> out_valid on two consecutive cycles, dout=1 then 4.

Source files
------------

// File: rtl/hls_ocr_mac_pipe_if.sv
// Beat/result bus for the pipelined multiply-accumulate block.
// The master drives the operand beats and the slave returns the window results.
interface hls_ocr_mac_pipe_if #(
   parameter int A_W   = 11,
   parameter int B_W   = 10,
   parameter int ACC_W = 32
);
   logic                    in_valid;
   logic signed [A_W-1:0]   din0;
   logic signed [B_W-1:0]   din1;
   logic                    in_first;
   logic                    in_last;
   logic signed [ACC_W-1:0] dout;
   logic                    out_valid;
   logic                    ovf;

   modport master (
      output in_valid, din0, din1, in_first, in_last,
      input  dout, out_valid, ovf
   );

   modport slave (
      input  in_valid, din0, din1, in_first, in_last,
      output dout, out_valid, ovf
   );
endinterface

// File: rtl/hls_ocr_mac_pipe.sv
// Signed multiply followed by windowed accumulation, with a saturating or wrapping
// accumulator. The ce input freezes every register, including the outputs.
module hls_ocr_mac_pipe #(
   parameter int A_W       = 11,
   parameter int B_W       = 10,
   parameter int ACC_W     = 32,
   parameter int MUL_STAGE = 2,
   parameter int SAT       = 1
) (
   input logic ap_clk,
   input logic ap_rst_n,
   input logic ce,
   hls_ocr_mac_pipe_if.slave s
);
   localparam int P_W = A_W + B_W;
   localparam int S_W = ACC_W + 1;
   localparam int L   = MUL_STAGE - 1;
   localparam logic [ACC_W-1:0] MAX_ACC = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_ACC = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [P_W-1:0]   prod;
   logic signed [P_W-1:0]   prod_q [MUL_STAGE];
   logic [MUL_STAGE-1:0]    vld_q, fst_q, lst_q;

   logic signed [ACC_W-1:0] acc_q;
   logic                    acc_ovf_q;
   logic signed [ACC_W-1:0] dout_q;
   logic                    out_valid_q;
   logic                    ovf_q;

   logic signed [S_W-1:0]   base;
   logic signed [S_W-1:0]   sum;
   logic                    range_err;
   logic signed [ACC_W-1:0] res;
   logic                    flag;

   assign prod = P_W'(s.din0) * P_W'(s.din1);

   // Beat flags carry the reset; invalid beats never reach the accumulator.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_q <= '0;
         fst_q <= '0;
         lst_q <= '0;
      end else if (ce) begin
         vld_q[0] <= s.in_valid;
         fst_q[0] <= s.in_first;
         lst_q[0] <= s.in_last;
         for (int i = 1; i < MUL_STAGE; i++) begin
            vld_q[i] <= vld_q[i-1];
            fst_q[i] <= fst_q[i-1];
            lst_q[i] <= lst_q[i-1];
         end
      end
   end

   // NOTE: the product pipeline is pure datapath qualified by vld_q, so it is
   // left without reset to keep it out of the asynchronous reset tree.
   always_ff @(posedge ap_clk) begin
      if (ce) begin
         prod_q[0] <= prod;
         for (int i = 1; i < MUL_STAGE; i++) prod_q[i] <= prod_q[i-1];
      end
   end

   // One guard bit above ACC_W is enough: |product| never exceeds 2^(ACC_W-1).
   // NOTE: every always_comb output gets a default first, so no latch can form.
   always_comb begin
      base      = fst_q[L] ? '0 : S_W'(acc_q);
      sum       = base + S_W'(prod_q[L]);
      range_err = sum[ACC_W] ^ sum[ACC_W-1];
      res       = sum[ACC_W-1:0];
      if (SAT != 0 && range_err) res = sum[ACC_W] ? MIN_ACC : MAX_ACC;
      flag      = (fst_q[L] ? 1'b0 : acc_ovf_q) | range_err;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together on the clock edge.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc_q       <= '0;
         acc_ovf_q   <= 1'b0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (ce) begin
         out_valid_q <= vld_q[L] & lst_q[L];
         if (vld_q[L]) begin
            if (lst_q[L]) begin
               dout_q    <= res;
               ovf_q     <= flag;
               acc_q     <= '0;
               acc_ovf_q <= 1'b0;
            end else begin
               acc_q     <= res;
               acc_ovf_q <= flag;
            end
         end
      end
   end

   assign s.dout      = dout_q;
   assign s.out_valid = out_valid_q;
   assign s.ovf       = ovf_q;
endmodule
